// File: rtl/video_timing_ctrl.sv
// Raster timing controller: walks hc/vc through active/porch/sync, pulls pixels and emits hs/vs/de/rgb.
// Latency: every output except pix_ready is registered one cycle after the counter state it reflects.
// Backpressure: none accepted downstream; a missing source pixel during active video outputs 0 and sets underflow.
module video_timing_ctrl #(
  parameter int H_ACT  = 640,
  parameter int H_FP   = 16,
  parameter int H_SYNC = 96,
  parameter int H_BP   = 48,
  parameter int V_ACT  = 480,
  parameter int V_FP   = 10,
  parameter int V_SYNC = 2,
  parameter int V_BP   = 33,
  parameter int HW     = 12,
  parameter int VW     = 12,
  parameter int DW     = 24
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          pix_valid,
  input  logic [DW-1:0] pix_data,
  output logic          pix_ready,
  output logic          hs,
  output logic          vs,
  output logic          de,
  output logic [DW-1:0] rgb,
  output logic [HW-1:0] x,
  output logic [VW-1:0] y,
  output logic          sof,
  output logic          underflow,
  output logic          running
);

  localparam int H_TOTAL = H_ACT + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACT + V_FP + V_SYNC + V_BP;

  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT_C  = HW'(H_ACT);
  localparam logic [HW-1:0] HS_START = HW'(H_ACT + H_FP);
  localparam logic [HW-1:0] HS_END   = HW'(H_ACT + H_FP + H_SYNC);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT_C  = VW'(V_ACT);
  localparam logic [VW-1:0] VS_START = VW'(V_ACT + V_FP);
  localparam logic [VW-1:0] VS_END   = VW'(V_ACT + V_FP + V_SYNC);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_STOP = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [HW-1:0]   hc_q, hc_d;
  logic [VW-1:0]   vc_q, vc_d;
  logic            de_q, de_d;
  logic            hs_q, hs_d;
  logic            vs_q, vs_d;
  logic            sof_q, sof_d;
  logic [DW-1:0]   rgb_q, rgb_d;
  logic [HW-1:0]   x_q, x_d;
  logic [VW-1:0]   y_q, y_d;
  logic            underflow_q, underflow_d;
  logic            running_q, running_d;

  logic counting;
  logic active;
  logic hsync;
  logic vsync;
  logic frame_end;

  assign counting  = (state_q != ST_IDLE);
  assign active    = (hc_q < H_ACT_C) && (vc_q < V_ACT_C);
  assign hsync     = (hc_q >= HS_START) && (hc_q < HS_END);
  assign vsync     = (vc_q >= VS_START) && (vc_q < VS_END);
  assign frame_end = (hc_q == H_LAST) && (vc_q == V_LAST);

  // Pixel is taken on every active cycle while counting; never depends on pix_valid.
  assign pix_ready = active && counting;

  // Next state: a stop request only takes effect at the last cycle of the frame.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (en) state_d = ST_RUN;
      ST_RUN:  if (!en) state_d = ST_STOP;
      ST_STOP: begin
        if (en)             state_d = ST_RUN;
        else if (frame_end) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Raster counters: held at the origin in IDLE, free-running otherwise.
  always_comb begin
    hc_d = hc_q;
    vc_d = vc_q;
    if (!counting) begin
      hc_d = '0;
      vc_d = '0;
    end else if (hc_q == H_LAST) begin
      hc_d = '0;
      vc_d = (vc_q == V_LAST) ? '0 : vc_q + 1'b1;
    end else begin
      hc_d = hc_q + 1'b1;
    end
  end

  // Output next-state: timing strobes gated by counting so IDLE stays quiet.
  always_comb begin
    de_d        = active && counting;
    hs_d        = hsync && counting;
    vs_d        = vsync && counting;
    sof_d       = counting && (hc_q == '0) && (vc_q == '0);
    x_d         = counting ? hc_q : x_q;
    y_d         = counting ? vc_q : y_q;
    rgb_d       = rgb_q;
    underflow_d = underflow_q;
    running_d   = (state_d != ST_IDLE);
    if (pix_ready) begin
      rgb_d = pix_valid ? pix_data : '0;
    end
    if (pix_ready && !pix_valid) begin
      underflow_d = 1'b1;
    end else if (!counting && !en) begin
      underflow_d = 1'b0;
    end
  end

  // State, counters and registered outputs; reset returns everything to an idle origin.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      hc_q        <= '0;
      vc_q        <= '0;
      de_q        <= 1'b0;
      hs_q        <= 1'b0;
      vs_q        <= 1'b0;
      sof_q       <= 1'b0;
      rgb_q       <= '0;
      x_q         <= '0;
      y_q         <= '0;
      underflow_q <= 1'b0;
      running_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      hc_q        <= hc_d;
      vc_q        <= vc_d;
      de_q        <= de_d;
      hs_q        <= hs_d;
      vs_q        <= vs_d;
      sof_q       <= sof_d;
      rgb_q       <= rgb_d;
      x_q         <= x_d;
      y_q         <= y_d;
      underflow_q <= underflow_d;
      running_q   <= running_d;
    end
  end

  assign de        = de_q;
  assign hs        = hs_q;
  assign vs        = vs_q;
  assign sof       = sof_q;
  assign rgb       = rgb_q;
  assign x         = x_q;
  assign y         = y_q;
  assign underflow = underflow_q;
  assign running   = running_q;

endmodule

// File: tb/tb_video_timing_ctrl.sv
// Directed bench for video_timing_ctrl with an 8x6 raster (48-cycle frame).
// Expected outputs come from closed-form raster formulas indexed by counted cycle.
// Source is always-valid except for one deliberately starved pixel.
module tb_video_timing_ctrl;

  localparam int DW = 24;
  localparam int HW = 12;
  localparam int VW = 12;

  logic          clk;
  logic          rst;
  logic          en;
  logic          pix_valid;
  logic [DW-1:0] pix_data;
  logic          pix_ready;
  logic          hs;
  logic          vs;
  logic          de;
  logic [DW-1:0] rgb;
  logic [HW-1:0] x;
  logic [VW-1:0] y;
  logic          sof;
  logic          underflow;
  logic          running;

  video_timing_ctrl #(
    .H_ACT(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACT(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HW(HW), .VW(VW), .DW(DW)
  ) dut (
    .clk(clk), .rst(rst), .en(en),
    .pix_valid(pix_valid), .pix_data(pix_data), .pix_ready(pix_ready),
    .hs(hs), .vs(vs), .de(de), .rgb(rgb), .x(x), .y(y),
    .sof(sof), .underflow(underflow), .running(running)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int k;
  int exp_pix;
  int uf_k;
  int uf_exp;
  int stop_k;
  logic consume_pend;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s (k=%0d): got %0h expected %0h", tag, k, got, exp);
    end
  endtask

  // One clock; the source advances its pixel after each accepted transfer.
  task automatic tick_step();
    consume_pend = pix_ready && pix_valid;
    @(posedge clk);
    #1;
    if (consume_pend) pix_data = pix_data + 1'b1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_de"},  32'(de), 0);
    chk({tag, "_hs"},  32'(hs), 0);
    chk({tag, "_vs"},  32'(vs), 0);
    chk({tag, "_sof"}, 32'(sof), 0);
    chk({tag, "_rgb"}, 32'(rgb), 0);
    chk({tag, "_x"},   32'(x), 0);
    chk({tag, "_y"},   32'(y), 0);
    chk({tag, "_uf"},  32'(underflow), 0);
    chk({tag, "_run"}, 32'(running), 0);
    chk({tag, "_rdy"}, 32'(pix_ready), 0);
  endtask

  // Outputs seen now reflect counted cycle kk; the counters already sit at kk+1.
  task automatic chk_frame(input int kk);
    int h, v, kn, h2, v2, e_de, e_rdy;
    h    = kk % 8;
    v    = (kk / 8) % 6;
    e_de = (h < 4 && v < 3) ? 1 : 0;
    chk("de",  32'(de), e_de);
    chk("hs",  32'(hs), (h >= 5 && h < 7) ? 1 : 0);
    chk("vs",  32'(vs), (v == 4) ? 1 : 0);
    chk("sof", 32'(sof), (kk % 48 == 0) ? 1 : 0);
    chk("x",   32'(x), h);
    chk("y",   32'(y), v);
    chk("running", 32'(running), (kk >= stop_k) ? 0 : 1);
    if (e_de == 1) begin
      if (kk == uf_k) begin
        chk("rgb_starved", 32'(rgb), 0);
        uf_exp = 1;
      end else begin
        chk("rgb", 32'(rgb), exp_pix);
        exp_pix++;
      end
    end
    chk("underflow", 32'(underflow), uf_exp);
    kn = kk + 1;
    h2 = kn % 8;
    v2 = (kn / 8) % 6;
    e_rdy = (kk >= stop_k) ? 0 : ((h2 < 4 && v2 < 3) ? 1 : 0);
    chk("pix_ready", 32'(pix_ready), e_rdy);
  endtask

  task automatic run_to(input int kend);
    while (k < kend) begin
      tick_step();
      k++;
      chk_frame(k);
    end
  endtask

  initial begin
    rst          = 1'b0;
    en           = 1'b1;
    pix_valid    = 1'b1;
    pix_data     = '0;
    consume_pend = 1'b0;
    k            = 0;
    exp_pix      = 0;
    uf_k         = -1;
    uf_exp       = 0;
    stop_k       = 1 << 30;

    // Reset held with en=1: everything stays at zero.
    for (int i = 0; i < 5; i++) begin
      tick_step();
      chk_all_zero("reset");
    end
    rst = 1'b1;

    // First edge samples en and enters RUN; sof shows on the second.
    tick_step();
    chk("start_running", 32'(running), 1);
    chk("start_sof", 32'(sof), 0);
    chk("start_de", 32'(de), 0);
    tick_step();
    k = 0;
    chk_frame(0);

    // Two clean frames.
    run_to(95);

    // Starve the third active pixel of line 1 in frame 2.
    uf_k = 106;
    run_to(105);
    pix_valid = 1'b0;
    run_to(106);
    pix_valid = 1'b1;

    // Stop request raised at line 2 and withdrawn at line 4 of frame 3: no visible effect.
    run_to(159);
    en = 1'b0;
    run_to(175);
    en = 1'b1;
    run_to(191);

    // Graceful stop requested at hc=3, vc=1 of frame 4; the frame completes.
    run_to(202);
    en = 1'b0;
    stop_k = 239;
    run_to(239);

    // Idle: quiet outputs, x/y hold, underflow cleared because en is low.
    for (int i = 0; i < 10; i++) begin
      tick_step();
      chk("idle_de", 32'(de), 0);
      chk("idle_sof", 32'(sof), 0);
      chk("idle_rdy", 32'(pix_ready), 0);
      chk("idle_run", 32'(running), 0);
      chk("idle_hs", 32'(hs), 0);
      chk("idle_vs", 32'(vs), 0);
      chk("idle_x", 32'(x), 7);
      chk("idle_y", 32'(y), 5);
      chk("idle_uf", 32'(underflow), 0);
    end

    // Restart from IDLE.
    stop_k = 1 << 30;
    uf_k   = -1;
    uf_exp = 0;
    en     = 1'b1;
    tick_step();
    chk("restart_running", 32'(running), 1);
    chk("restart_sof", 32'(sof), 0);
    k = 0;
    tick_step();
    chk_frame(0);
    run_to(9);

    // Asynchronous reset while the counters sit at hc=2, vc=1.
    #2;
    rst = 1'b0;
    #1;
    chk_all_zero("async_rst");
    tick_step();
    chk_all_zero("async_hold");
    tick_step();
    chk_all_zero("async_hold");
    rst = 1'b1;
    tick_step();
    chk("rerun_running", 32'(running), 1);
    k = 0;
    tick_step();
    chk_frame(0);
    run_to(20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
